// File: rtl/fire_suppression_ctrl_if.sv
// Indicator, command and status signals between the fire suppression
// sequencer and its environment.
interface fire_suppression_ctrl_if #(
  parameter int MAX_BURSTS = 3
);
  localparam int BW = $clog2(MAX_BURSTS + 1);

  logic [1:0]    fire_indicators;
  logic          manual_trigger;
  logic          abort;
  logic          ack;
  logic          fire_extinguisher;
  logic          alarm;
  logic          fault;
  logic [BW-1:0] burst_cnt;
  logic [2:0]    state;

  modport master (
    output fire_indicators, manual_trigger, abort, ack,
    input  fire_extinguisher, alarm, fault, burst_cnt, state
  );

  modport slave (
    input  fire_indicators, manual_trigger, abort, ack,
    output fire_extinguisher, alarm, fault, burst_cnt, state
  );
endinterface

// File: rtl/fire_suppression_ctrl.sv
// Fire extinguisher sequencer: confirms a fire on both indicators, runs timed
// spray bursts with cooldowns, and locks out after too many bursts.
module fire_suppression_ctrl #(
  parameter int CONFIRM_CYCLES  = 8,
  parameter int SPRAY_CYCLES    = 100,
  parameter int COOLDOWN_CYCLES = 50,
  parameter int MAX_BURSTS      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fire_suppression_ctrl_if.slave   bus
);

  localparam int MAX_AB = (CONFIRM_CYCLES > SPRAY_CYCLES) ? CONFIRM_CYCLES : SPRAY_CYCLES;
  localparam int MAX_T  = (MAX_AB > COOLDOWN_CYCLES) ? MAX_AB : COOLDOWN_CYCLES;
  localparam int TW     = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int BW     = $clog2(MAX_BURSTS + 1);

  localparam logic [TW-1:0] CONFIRM_LAST  = TW'(CONFIRM_CYCLES - 1);
  localparam logic [TW-1:0] SPRAY_LAST    = TW'(SPRAY_CYCLES - 1);
  localparam logic [TW-1:0] COOLDOWN_LAST = TW'(COOLDOWN_CYCLES - 1);
  localparam logic [BW-1:0] BURST_LIMIT   = BW'(MAX_BURSTS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONFIRM  = 3'd1,
    SPRAY    = 3'd2,
    COOLDOWN = 3'd3,
    LOCKOUT  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          fire;

  assign fire = &bus.fire_indicators;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    burst_d = burst_q;

    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.manual_trigger) begin
          state_d = SPRAY;
          burst_d = BW'(1);
        end else if (fire) begin
          state_d = CONFIRM;
        end
      end
      CONFIRM: begin
        if (bus.abort || !fire) begin
          state_d = IDLE;
        end else if (timer_q == CONFIRM_LAST) begin
          state_d = SPRAY;
          burst_d = BW'(1);
        end
      end
      SPRAY: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (timer_q == SPRAY_LAST) begin
          state_d = COOLDOWN;
        end
      end
      COOLDOWN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (timer_q == COOLDOWN_LAST) begin
          if (!fire) begin
            state_d = IDLE;
          end else if (burst_q < BURST_LIMIT) begin
            state_d = SPRAY;
            burst_d = burst_q + BW'(1);
          end else begin
            state_d = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        timer_d = '0;
        if (bus.ack) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The shared timer restarts on every state change; the incident ends on IDLE entry.
    if (state_d != state_q) begin
      timer_d = '0;
    end
    if (state_d == IDLE) begin
      burst_d = '0;
    end
  end

  assign bus.fire_extinguisher = (state_q == SPRAY);
  assign bus.alarm             = (state_q != IDLE);
  assign bus.fault             = (state_q == LOCKOUT);
  assign bus.burst_cnt         = burst_q;
  assign bus.state             = state_q;

endmodule
